rdid_spi_master: RTL and testbench
==================================

# rdid_spi_master

SPI master that issues the JEDEC Read-Identification instruction (0x9F) to the board's serial flash. It shifts back the 3-byte ID and registers it as manufacture_id, memory_type and memory_capacity. It sits between the flash pins and the LED display multiplexer, which selects one of the three bytes with the switches. One transaction runs per start request. The bus is SPI mode 0 with a programmable SCK divider.

## Interface
Parameters:
- CLK_DIV, 4, system clock cycles per SCK half-period; legal range 1..255.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- rst_n  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
- start  input  1  request one RDID transaction; level-sampled; accepted only while busy=0.
- busy  output  1  high from the cycle after acceptance until the done cycle (exclusive).
- done  output  1  single-cycle pulse; ID outputs are valid from this cycle on.
- cs_n  output  1  flash chip select, active low.
- sck  output  1  SPI clock; idles low (mode 0).
- mosi  output  1  command data to flash.
- miso  input  1  data from flash.
- manufacture_id  output  8  first byte returned.
- memory_type  output  8  second byte returned.
- memory_capacity  output  8  third byte returned.

## Operation
- States:
  - IDLE: wait for start.
  - SETUP: cs_n low, SCK held low for CLK_DIV cycles.
  - SHIFT: 32 SCK periods.
  - HOLD: SCK low, cs_n low for CLK_DIV cycles.
  - DONE: one cycle, then IDLE.
- IDLE -> SETUP when start=1 is sampled. cs_n=0 and mosi=1 (bit 7 of 0x9F) drive from the next cycle.
- SHIFT:
  - A half-period counter (0..CLK_DIV-1) toggles sck when it reaches CLK_DIV-1.
  - An edge counter counts 64 SCK edges.
  - Rising edge: shift miso into a 24-bit register, MSB first. Sampling starts with the 9th rising edge (the first data bit); the 8 command-phase samples are discarded.
  - Falling edge: advance mosi to the next command bit, 1,0,0,1,1,1,1,1 MSB first. After the 8th falling edge mosi=0 for the remainder.
- SHIFT -> HOLD on the 64th edge (the 32nd falling edge, sck back low).
- HOLD -> DONE after CLK_DIV cycles. In DONE:
  - cs_n=1, done=1, busy=0.
  - manufacture_id=shift[23:16], memory_type=shift[15:8], memory_capacity=shift[7:0] are all loaded in this cycle.
- ID outputs change only in the DONE cycle and hold between transactions.
- start sampled during busy=1 is ignored; it is not queued.
- start=1 in the DONE cycle is accepted and begins a new transaction.
- Held start produces back-to-back transactions, with cs_n high for exactly one cycle between them.
- Reset values: cs_n=1, sck=0, mosi=0, busy=0, done=0, all ID outputs 0x00, state IDLE.
- Reset mid-transaction: on the first clk edge with rst_n=0, cs_n=1 and sck=0 immediately, the shift register is discarded and the ID outputs are cleared to 0. No done pulse is produced.

## Timing
- Let T0 be the edge where start is accepted, with D=CLK_DIV.
- cs_n falls and busy rises at T0+1.
- First sck rise at T0+1+D. Thereafter an sck edge every D cycles. The 64th edge (last fall) occurs at T0+1+64D.
- DONE cycle: cs_n rise, done, busy fall and outputs valid all at T0+1+65D. For D=4 this is 261 cycles after T0.
- MOSI setup before each rising edge is D cycles. miso is sampled with the same clk edge that raises sck, i.e. it is sampled D cycles after the preceding falling edge.
- cs_n setup before the first rise is D cycles; cs_n hold after the last fall is D cycles.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset:** hold rst_n=0 for 3 cycles -> cs_n=1, sck=0, mosi=0, busy=0, done=0, IDs 0x00.
- **Basic read:** flash model with CLK_DIV=4 drives 0xEF,0x40,0x18 on falling edges after the command; pulse start -> exactly 32 sck rises; mosi carries 0x9F on rises 1-8 and 0 after; done at T0+261 with manufacture_id=0xEF, memory_type=0x40, memory_capacity=0x18.
- **Ignored start:** raise start again mid-SHIFT -> no restart, one done, IDs unchanged.
- **Held start:** hold start high for two transactions with the model returning 0x01,0x20,0x18 then 0xC2,0x20,0x17 -> cs_n high exactly 1 cycle between transactions; IDs update in each done cycle.
- **Reset mid-shift:** assert rst_n=0 after 12 sck rises -> cs_n=1, sck=0 next edge; IDs 0; no done; a following start completes normally.
- **Minimum divider:** CLK_DIV=1 with the model returning 0xFF,0x00,0xA5 -> done at T0+66, IDs match.

Source files
------------

// File: rtl/rdid_spi_master.sv
// SPI mode-0 master that issues JEDEC RDID (0x9F) and registers the 3-byte flash ID.
// One transaction per accepted start; SCK half-period is CLK_DIV system clocks.
//
// state | meaning
// IDLE  | waiting for start
// SETUP | cs_n low, sck low, mosi holds command MSB for CLK_DIV cycles
// SHIFT | 64 sck edges: 8 command bits out, then 24 ID bits in
// HOLD  | sck low, cs_n still low for CLK_DIV cycles
// DONE  | one-cycle done pulse, ID outputs loaded, start re-accepted here
module rdid_spi_master #(
  parameter int CLK_DIV = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic       busy,
  output logic       done,
  output logic       cs_n,
  output logic       sck,
  output logic       mosi,
  input  logic       miso,
  output logic [7:0] manufacture_id,
  output logic [7:0] memory_type,
  output logic [7:0] memory_capacity
);

  typedef enum logic [2:0] {IDLE, SETUP, SHIFT, HOLD, DONE} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] RDID_CMD = 8'h9F;

  state_t      state, state_nxt;
  logic [7:0]  half_cnt;
  logic [5:0]  edge_cnt;
  logic [7:0]  cmd;
  logic [23:0] shift;
  logic        accept, tick, sck_edge, last_edge, hold_end;

  // mosi is the MSB of the command shifter, so it stays a flop output
  assign mosi = cmd[7];

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    sck_edge  = 1'b0;
    last_edge = 1'b0;
    hold_end  = 1'b0;
    tick      = (half_cnt == DIV_LAST);
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = SETUP;
        end else begin
          state_nxt = IDLE;
        end
      end
      // The end of SETUP is itself the first sck rise
      SETUP: begin
        if (tick) begin
          sck_edge  = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (tick) begin
          sck_edge = 1'b1;
          if (edge_cnt == 6'd63) begin
            last_edge = 1'b1;
            state_nxt = HOLD;
          end
        end
      end
      HOLD: begin
        if (tick) begin
          hold_end  = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state           <= IDLE;
      half_cnt        <= 8'd0;
      edge_cnt        <= 6'd0;
      cmd             <= 8'd0;
      shift           <= 24'd0;
      sck             <= 1'b0;
      cs_n            <= 1'b1;
      busy            <= 1'b0;
      done            <= 1'b0;
      manufacture_id  <= 8'd0;
      memory_type     <= 8'd0;
      memory_capacity <= 8'd0;
    end else begin
      state <= state_nxt;
      done  <= 1'b0;

      if (accept || tick) begin
        half_cnt <= 8'd0;
      end else if (state != IDLE && state != DONE) begin
        half_cnt <= half_cnt + 8'd1;
      end

      if (accept) begin
        cs_n     <= 1'b0;
        busy     <= 1'b1;
        sck      <= 1'b0;
        cmd      <= RDID_CMD;
        edge_cnt <= 6'd0;
        shift    <= 24'd0;
      end

      if (sck_edge) begin
        sck      <= ~sck;
        edge_cnt <= edge_cnt + 6'd1;
        // first 8 rises belong to the command phase and are discarded
        if (!sck && edge_cnt >= 6'd16) begin
          shift <= {shift[22:0], miso};
        end
        if (sck) begin
          cmd <= {cmd[6:0], 1'b0};
        end
      end

      if (last_edge) begin
        edge_cnt <= 6'd0;
      end

      if (hold_end) begin
        cs_n            <= 1'b1;
        busy            <= 1'b0;
        done            <= 1'b1;
        manufacture_id  <= shift[23:16];
        memory_type     <= shift[15:8];
        memory_capacity <= shift[7:0];
      end
    end
  end

endmodule

// File: tb/tb_rdid_spi_master.sv
// Scoreboard bench for rdid_spi_master: two instances (CLK_DIV=4 and CLK_DIV=1),
// each with a behavioural flash model and a transaction-level timing reference.
module tb_rdid_spi_master;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic       start[2] = '{1'b0, 1'b0};
  logic       miso[2]  = '{1'b0, 1'b0};
  logic       busy[2], done[2], cs_n[2], sck[2], mosi[2];
  logic [7:0] mid[2], mty[2], mcap[2];

  int edge_n   = 0;
  int checks   = 0;
  int failures = 0;

  logic [23:0] plan[2][8];
  int          plan_n[2] = '{0, 0};

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : inst
    localparam int D = (g == 0) ? 4 : 1;

    rdid_spi_master #(.CLK_DIV(D)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .start          (start[g]),
      .busy           (busy[g]),
      .done           (done[g]),
      .cs_n           (cs_n[g]),
      .sck            (sck[g]),
      .mosi           (mosi[g]),
      .miso           (miso[g]),
      .manufacture_id (mid[g]),
      .memory_type    (mty[g]),
      .memory_capacity(mcap[g])
    );

    logic [23:0] exp_id[$];
    int          exp_edge[$];
    int          t_done    = -1;
    int          plan_rd   = 0;
    logic [23:0] active_id = 24'd0;
    logic [23:0] held_ids  = 24'd0;
    bit          rst_seen  = 1'b1;

    // Reference: a start seen while free opens a transaction finishing 65*D edges later
    always begin
      @(posedge clk);
      #1;
      rst_seen = !rst_n;
      if (!rst_n) begin
        exp_id.delete();
        exp_edge.delete();
        t_done   = -1;
        held_ids = 24'd0;
      end else if (start[g] && edge_n > t_done) begin
        if (plan_rd < plan_n[g]) begin
          active_id = plan[g][plan_rd];
          plan_rd++;
        end else begin
          active_id = 24'($urandom);
        end
        t_done = edge_n + 65 * D;
        exp_id.push_back(active_id);
        exp_edge.push_back(t_done);
      end
    end

    always @(negedge clk) begin
      logic [23:0] eid;
      int          et;
      if (rst_seen) begin
        check($sformatf("rst_cs_n[%0d]", g), cs_n[g], 1);
        check($sformatf("rst_sck[%0d]", g), sck[g], 0);
        check($sformatf("rst_mosi[%0d]", g), mosi[g], 0);
        check($sformatf("rst_done[%0d]", g), done[g], 0);
      end
      check($sformatf("busy[%0d]", g), busy[g], (edge_n < t_done) ? 1 : 0);
      if (done[g]) begin
        if (exp_id.size() == 0) begin
          check($sformatf("done_unexpected[%0d]", g), done[g], 0);
        end else begin
          eid = exp_id.pop_front();
          et  = exp_edge.pop_front();
          check($sformatf("done_edge[%0d]", g), edge_n, et);
          check($sformatf("id[%0d]", g), {mid[g], mty[g], mcap[g]}, eid);
          held_ids = eid;
        end
      end else if (exp_edge.size() > 0 && edge_n > exp_edge[0]) begin
        check($sformatf("done_missing[%0d]", g), done[g], 1);
        void'(exp_id.pop_front());
        void'(exp_edge.pop_front());
      end
      check($sformatf("ids_held[%0d]", g), {mid[g], mty[g], mcap[g]}, held_ids);
    end

    // Flash: records mosi on sck rises, drives ID bits after each falling edge past the 8th
    int          rises = 0, falls = 0;
    logic [31:0] mosi_bits = 32'd0;
    bit          prev_cs = 1'b1, prev_sck = 1'b0, aborted = 1'b0;

    always begin
      @(posedge clk);
      #1;
      if (!rst_n) aborted = 1'b1;
      if (!cs_n[g]) begin
        if (sck[g] && !prev_sck) begin
          rises++;
          mosi_bits = {mosi_bits[30:0], mosi[g]};
        end
        if (!sck[g] && prev_sck) begin
          falls++;
          if (falls >= 8 && falls < 32) miso[g] = active_id[31 - falls];
        end
      end
      if (cs_n[g] && !prev_cs && !aborted) begin
        check($sformatf("sck_rises[%0d]", g), rises, 32);
        check($sformatf("mosi_cmd[%0d]", g), mosi_bits, 32'h9F00_0000);
      end
      if (cs_n[g]) begin
        rises     = 0;
        falls     = 0;
        mosi_bits = 32'd0;
        miso[g]   = 1'b0;
        if (rst_n) aborted = 1'b0;
      end
      prev_cs  = cs_n[g];
      prev_sck = sck[g];
    end
  end

  task automatic pulse(input int g);
    @(negedge clk);
    start[g] = 1'b1;
    @(negedge clk);
    start[g] = 1'b0;
  endtask

  task automatic wait_done(input int g, input int limit);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done[g] && n < limit);
    if (!done[g]) check($sformatf("timeout[%0d]", g), done[g], 1);
  endtask

  task automatic add_plan(input int g, input logic [23:0] id);
    plan[g][plan_n[g]] = id;
    plan_n[g]++;
  endtask

  initial begin
    int rises_seen;
    int n;
    bit prev;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    add_plan(0, 24'hEF4018);
    pulse(0);
    wait_done(0, 400);

    add_plan(0, 24'($urandom));
    pulse(0);
    repeat (100) @(negedge clk);
    pulse(0);
    wait_done(0, 400);
    repeat (5) @(negedge clk);

    add_plan(0, 24'h012018);
    add_plan(0, 24'hC22017);
    @(negedge clk);
    start[0] = 1'b1;
    wait_done(0, 400);
    check("cs_gap_hi", cs_n[0], 1);
    @(negedge clk);
    check("cs_gap_lo", cs_n[0], 0);
    wait_done(0, 400);
    start[0] = 1'b0;
    repeat (5) @(negedge clk);

    add_plan(1, 24'hFF00A5);
    pulse(1);
    wait_done(1, 100);
    for (int i = 0; i < 4; i++) begin
      pulse(1);
      wait_done(1, 100);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    pulse(0);
    rises_seen = 0;
    n = 0;
    prev = sck[0];
    while (rises_seen < 12 && n < 300) begin
      @(negedge clk);
      n++;
      if (sck[0] && !prev) rises_seen++;
      prev = sck[0];
    end
    check("midrst_rises", rises_seen, 12);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_cs_n", cs_n[0], 1);
    check("midrst_sck", sck[0], 0);
    check("midrst_ids", {mid[0], mty[0], mcap[0]}, 0);
    rst_n = 1'b1;
    repeat (300) @(negedge clk);

    pulse(0);
    wait_done(0, 400);
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
